// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: DDR3 command responder with 256-byte store. Ports: clk, RESET_SM_button (async high), CS/RAS/CAS/WE (active-low cmd), Addr_in, BA_in, DQ_in, LDM in; DQ_out, DQ_oe, LDQS_out, bank_open, cmd_err, state out.
module ddr3_cmd_responder #(
  parameter int CL = 6,
  parameter int CWL = 5,
  parameter int TRCD = 4,
  parameter int TRFC = 52
) (
  input  logic        clk,
  input  logic        RESET_SM_button,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr_in,
  input  logic [2:0]  BA_in,
  input  logic [7:0]  DQ_in,
  input  logic        LDM,
  output logic [7:0]  DQ_out,
  output logic        DQ_oe,
  output logic        LDQS_out,
  output logic [7:0]  bank_open,
  output logic        cmd_err,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST, REFRESH} state_t;
  localparam logic [3:0] C_ACT = 4'b0011, C_WR = 4'b0100, C_RD = 4'b0101, C_PRE = 4'b0010,
                         C_REF = 4'b0001, C_NOP = 4'b0111;
  localparam logic [7:0] CL8 = 8'(CL), CWL8 = 8'(CWL), TRCD8 = 8'(TRCD), TRFC8 = 8'(TRFC);
  state_t      st;
  logic [7:0]  mem [256];
  logic [7:0]  cnt, trcd_cnt;
  logic [2:0]  beat, b_ba;
  logic [1:0]  b_col;
  logic        b_bl8, b_ap;
  logic [3:0]  cmd;
  logic        nop, last;
  logic [7:0]  idx;
  assign cmd   = {CS, RAS, CAS, WE};
  assign nop   = CS || cmd == C_NOP;
  assign last  = beat == (b_bl8 ? 3'd7 : 3'd3);
  assign idx   = {b_ba, b_col, beat};
  assign state = st;
  // Memory has no reset; stores only happen in WR_BURST, which reset leaves immediately.
  always_ff @(posedge clk)
    if (st == WR_BURST && !LDM) mem[idx] <= DQ_in;
  always_ff @(posedge clk or posedge RESET_SM_button)
    if (RESET_SM_button) begin
      st        <= IDLE;
      bank_open <= '0;
      DQ_out    <= '0;
      DQ_oe     <= 1'b0;
      LDQS_out  <= 1'b0;
      cmd_err   <= 1'b0;
      cnt       <= '0;
      trcd_cnt  <= '0;
      beat      <= '0;
      b_ba      <= '0;
      b_col     <= '0;
      b_bl8     <= 1'b0;
      b_ap      <= 1'b0;
    end else begin
      cmd_err  <= st != IDLE && !nop;
      DQ_oe    <= 1'b0;
      DQ_out   <= '0;
      LDQS_out <= 1'b0;
      if (trcd_cnt != TRCD8) trcd_cnt <= trcd_cnt + 8'd1;
      case (st)
        IDLE:
          if (!nop) begin
            if (cmd == C_ACT) begin
              if (bank_open[BA_in]) cmd_err <= 1'b1;
              else begin
                bank_open[BA_in] <= 1'b1;
                trcd_cnt         <= '0;
              end
            end else if (cmd == C_WR || cmd == C_RD) begin
              // trcd_cnt lags the elapsed cycle count by one, hence the +1.
              if (!bank_open[BA_in] || trcd_cnt + 8'd1 < TRCD8) cmd_err <= 1'b1;
              else begin
                st    <= cmd == C_WR ? WR_WAIT : RD_WAIT;
                cnt   <= 8'd1;
                b_ba  <= BA_in;
                b_col <= Addr_in[4:3];
                b_bl8 <= Addr_in[12];
                b_ap  <= Addr_in[10];
              end
            end else if (cmd == C_PRE) begin
              if (Addr_in[10]) bank_open <= '0;
              else bank_open[BA_in] <= 1'b0;
            end else if (cmd == C_REF) begin
              if (|bank_open) cmd_err <= 1'b1;
              else begin
                st  <= REFRESH;
                cnt <= 8'd1;
              end
            end
          end
        WR_WAIT, RD_WAIT:
          if (cnt == (st == WR_WAIT ? CWL8 : CL8) - 8'd1) begin
            st   <= st == WR_WAIT ? WR_BURST : RD_BURST;
            beat <= '0;
          end else cnt <= cnt + 8'd1;
        WR_BURST, RD_BURST: begin
          if (st == RD_BURST) begin
            DQ_oe    <= 1'b1;
            DQ_out   <= mem[idx];
            LDQS_out <= ~beat[0];
          end
          if (last) begin
            st <= IDLE;
            if (b_ap) bank_open[b_ba] <= 1'b0;
          end else beat <= beat + 3'd1;
        end
        REFRESH:
          if (cnt == TRFC8) st <= IDLE;
          else cnt <= cnt + 8'd1;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// tb_ddr3_cmd_responder: directed scoreboard bench for ddr3_cmd_responder.
module tb_ddr3_cmd_responder;
  localparam int CL = 6, CWL = 5, TRCD = 4, TRFC = 52;
  localparam logic [3:0] ACT = 4'b0011, WRC = 4'b0100, RDC = 4'b0101, PRE = 4'b0010,
                         REF = 4'b0001, MRS = 4'b0000, ZQCL = 4'b0110, NOP = 4'b0111;
  logic        clk = 1'b0, rst = 1'b1;
  logic        CS = 1'b0, RAS = 1'b1, CAS = 1'b1, WE = 1'b1, LDM = 1'b0;
  logic [14:0] Addr_in = '0;
  logic [2:0]  BA_in = '0;
  logic [7:0]  DQ_in = '0;
  logic [7:0]  DQ_out, bank_open;
  logic        DQ_oe, LDQS_out, cmd_err;
  logic [2:0]  state;
  typedef struct {int cyc; logic [7:0] d; logic s;} exp_t;
  exp_t        q[$];
  logic [7:0]  model [256];
  int          cyc = 0, vecs = 0, errs = 0;
  ddr3_cmd_responder #(.CL(CL), .CWL(CWL), .TRCD(TRCD), .TRFC(TRFC)) dut (
    .clk(clk), .RESET_SM_button(rst), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .Addr_in(Addr_in), .BA_in(BA_in), .DQ_in(DQ_in), .LDM(LDM), .DQ_out(DQ_out),
    .DQ_oe(DQ_oe), .LDQS_out(LDQS_out), .bank_open(bank_open), .cmd_err(cmd_err), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() != 0 && q[0].cyc == cyc) begin
      chk("rd_beat", {DQ_oe, LDQS_out, DQ_out}, {1'b1, q[0].s, q[0].d});
      void'(q.pop_front());
    end else chk("idle_dq", {DQ_oe, LDQS_out, DQ_out}, 0);
  endtask
  task automatic issue(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a, input logic err);
    {CS, RAS, CAS, WE} = c;
    BA_in = ba;
    Addr_in = a;
    tick();
    {CS, RAS, CAS, WE} = NOP;
    Addr_in = '0;
    chk("cmd_err", cmd_err, err);
  endtask
  function automatic logic [14:0] ca(input logic [1:0] col, input logic bl8, input logic ap);
    logic [14:0] a;
    a = 15'(col) << 3;
    a[12] = bl8;
    a[10] = ap;
    return a;
  endfunction
  task automatic act(input logic [2:0] ba);
    issue(ACT, ba, 15'd5, 1'b0);
    repeat (TRCD - 1) tick();
  endtask
  task automatic wr(input logic [2:0] ba, input logic [1:0] col, input logic bl8, input logic ap,
                    input logic [63:0] d, input logic [7:0] m);
    int n;
    n = bl8 ? 8 : 4;
    issue(WRC, ba, ca(col, bl8, ap), 1'b0);
    for (int j = 1; j < CWL + n; j++) begin
      if (j >= CWL) begin
        DQ_in = d[8*(j-CWL) +: 8];
        LDM = m[j-CWL];
        if (!m[j-CWL]) model[{ba, col, 3'(j-CWL)}] = d[8*(j-CWL) +: 8];
      end
      tick();
    end
    LDM = 1'b0;
    DQ_in = '0;
  endtask
  task automatic rd_start(input logic [2:0] ba, input logic [1:0] col, input logic bl8);
    int t;
    issue(RDC, ba, ca(col, bl8, 1'b0), 1'b0);
    t = cyc;
    for (int k = 0; k < (bl8 ? 8 : 4); k++) q.push_back('{t + CL + k, model[{ba, col, 3'(k)}], k % 2 == 0});
  endtask
  task automatic rd(input logic [2:0] ba, input logic [1:0] col, input logic bl8);
    rd_start(ba, col, bl8);
    repeat (CL + (bl8 ? 8 : 4)) tick();
    chk("rd_drained", q.size(), 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_bank", bank_open, 0);
    chk("rst_err", cmd_err, 0);
    rst = 1'b0;
    issue(MRS, 3'd0, '0, 1'b0);
    issue(ZQCL, 3'd0, '0, 1'b0);
    chk("noop_state", state, 0);
    act(3'd5);
    chk("act_open", bank_open, 8'h20);
    wr(3'd5, 2'd1, 1'b1, 1'b0, 64'h17161514_13121110, 8'h00);
    tick();
    rd(3'd5, 2'd1, 1'b1);
    wr(3'd5, 2'd2, 1'b1, 1'b0, {8{8'hAA}}, 8'h00);
    wr(3'd5, 2'd2, 1'b0, 1'b0, 64'h53525150, 8'h04);
    rd(3'd5, 2'd2, 1'b0);
    rd(3'd5, 2'd2, 1'b1);
    issue(ACT, 3'd2, 15'd9, 1'b0);
    tick();
    issue(RDC, 3'd2, ca(2'd0, 1'b1, 1'b0), 1'b1);
    tick();
    chk("err_pulse_one", cmd_err, 0);
    repeat (CL + 8) tick();
    issue(RDC, 3'd1, ca(2'd0, 1'b1, 1'b0), 1'b1);
    issue(ACT, 3'd2, 15'd7, 1'b1);
    issue(ACT, 3'd2, 15'd7, 1'b1);
    chk("act_open_unch", bank_open, 8'h24);
    act(3'd3);
    issue(REF, 3'd0, '0, 1'b1);
    issue(PRE, 3'd2, '0, 1'b0);
    issue(PRE, 3'd2, '0, 1'b0);
    chk("pre_one", bank_open, 8'h28);
    issue(PRE, 3'd0, 15'h0400, 1'b0);
    chk("pre_all", bank_open, 0);
    issue(REF, 3'd0, '0, 1'b0);
    chk("ref_state", state, 5);
    for (int j = 1; j < TRFC; j++) begin
      if (j == 10) issue(ACT, 3'd1, 15'd1, 1'b1);
      else tick();
      chk("ref_hold", state, 5);
    end
    tick();
    chk("ref_done", state, 0);
    chk("ref_bank", bank_open, 0);
    act(3'd4);
    wr(3'd4, 2'd1, 1'b1, 1'b1, 64'hC7C6C5C4_C3C2C1C0, 8'h00);
    chk("ap_close", bank_open, 0);
    act(3'd4);
    rd_start(3'd4, 2'd1, 1'b1);
    repeat (CL + 3) tick();
    rst = 1'b1;
    #1;
    chk("abort_oe", DQ_oe, 0);
    chk("abort_state", state, 0);
    chk("abort_bank", bank_open, 0);
    q.delete();
    tick();
    rst = 1'b0;
    act(3'd5);
    rd(3'd5, 2'd1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
